// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a} and the PWM phase count.
package sev_seg_pkg;

  localparam int PHASES = 16;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7_decode
  import sev_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Full 16-entry lookup
  always_comb begin
    pattern = SEG_OFF;
    case (nibble)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_E;
      4'hF:    pattern = SEG_F;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed N-digit common-anode display driver with PWM brightness
// and frame-aligned commit of new contents.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SUB_DIV    = 6250,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [NUM_DIGITS-1:0]   upd_blank,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int SW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SUB_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [3:0]    PHASE_LAST = 4'(PHASES - 1);
  localparam logic          INV        = (ACTIVE_LOW == 0);

  logic [SW-1:0]           sub_cnt_r;
  logic [3:0]              phase_r;
  logic [DW-1:0]           digit_idx_r;
  logic                    sub_wrap_s;
  logic                    phase_wrap_s;
  logic                    boundary_s;
  logic                    capture_s;

  logic                    pend_r;
  logic [4*NUM_DIGITS-1:0] pend_digits_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blank_r;
  logic [4*NUM_DIGITS-1:0] act_digits_r;
  logic [NUM_DIGITS-1:0]   act_dp_r;
  logic [NUM_DIGITS-1:0]   act_blank_r;

  logic [3:0]              nibble_s;
  logic [6:0]              pattern_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic                    dp_s;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic                    frame_tick_r;

  assign sub_wrap_s   = (sub_cnt_r == SUB_LAST);
  assign phase_wrap_s = sub_wrap_s && (phase_r == PHASE_LAST);
  assign boundary_s   = phase_wrap_s && (digit_idx_r == DIGIT_LAST);
  assign capture_s    = upd_valid && !pend_r;

  // Subslot, PWM phase and digit scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt_r   <= {SW{1'b0}};
      phase_r     <= 4'd0;
      digit_idx_r <= {DW{1'b0}};
    end else begin
      sub_cnt_r <= sub_wrap_s ? {SW{1'b0}} : sub_cnt_r + {{(SW-1){1'b0}}, 1'b1};
      if (sub_wrap_s) phase_r <= phase_r + 4'd1;
      if (phase_wrap_s)
        digit_idx_r <= boundary_s ? {DW{1'b0}} : digit_idx_r + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // Pending capture; a capture never coincides with a commit since both need opposite pend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r        <= 1'b0;
      pend_digits_r <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r     <= {NUM_DIGITS{1'b0}};
      pend_blank_r  <= {NUM_DIGITS{1'b0}};
    end else if (capture_s) begin
      pend_r        <= 1'b1;
      pend_digits_r <= upd_digits;
      pend_dp_r     <= upd_dp;
      pend_blank_r  <= upd_blank;
    end else if (boundary_s) begin
      pend_r        <= 1'b0;
    end
  end

  // Active contents change only at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_digits_r <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r     <= {NUM_DIGITS{1'b0}};
      act_blank_r  <= {NUM_DIGITS{1'b1}};
    end else if (boundary_s && pend_r) begin
      act_digits_r <= pend_digits_r;
      act_dp_r     <= pend_dp_r;
      act_blank_r  <= pend_blank_r;
    end
  end

  assign nibble_s = act_digits_r[{digit_idx_r, 2'b00} +: 4];

  hex7_decode u_decode (
    .nibble  (nibble_s),
    .pattern (pattern_s)
  );

  // Active-low drive values for the currently selected digit
  always_comb begin
    lit_s = (phase_r <= bright) && !act_blank_r[digit_idx_r];
    an_s  = {NUM_DIGITS{1'b1}};
    seg_s = SEG_OFF;
    dp_s  = 1'b1;
    if (lit_s) begin
      an_s[digit_idx_r] = 1'b0;
      seg_s             = pattern_s;
      dp_s              = !act_dp_r[digit_idx_r];
    end else begin
      an_s  = {NUM_DIGITS{1'b1}};
      seg_s = SEG_OFF;
      dp_s  = 1'b1;
    end
  end

  // Output registers with polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r         <= {NUM_DIGITS{1'b1}} ^ {NUM_DIGITS{INV}};
      seg_r        <= SEG_OFF ^ {7{INV}};
      dp_r         <= 1'b1 ^ INV;
      frame_tick_r <= 1'b0;
    end else begin
      an_r         <= an_s ^ {NUM_DIGITS{INV}};
      seg_r        <= seg_s ^ {7{INV}};
      dp_r         <= dp_s ^ INV;
      frame_tick_r <= boundary_s;
    end
  end

  assign upd_ready  = !pend_r;
  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed bench for sev_seg_scan with 4 digits, 2-cycle subslots (128-cycle frames).
module tb_sev_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_digits = 16'h0000;
  logic [3:0]  upd_dp = 4'h0;
  logic [3:0]  upd_blank = 4'h0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int tests = 0;
  int failed = 0;

  sev_seg_scan #(.NUM_DIGITS(4), .SUB_DIV(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_digits(upd_digits), .upd_dp(upd_dp), .upd_blank(upd_blank),
    .bright(bright), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steps until frame_tick is seen (at least one step), bounded.
  task automatic wait_tick(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 300);
    check(tag, {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic check_digit(input string tag, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
    check({tag, "_an"}, {28'd0, an}, {28'd0, e_an});
    check({tag, "_seg"}, {25'd0, seg}, {25'd0, e_seg});
    check({tag, "_dp"}, {31'd0, dp}, {31'd0, e_dp});
  endtask

  int n;
  int rdy_cnt;
  int dark_cnt;
  int tick_cnt;
  int cnt [4];

  initial begin
    // 1. reset and idle
    step(2);
    check_digit("rst", 4'hF, 7'h7F, 1'b1);
    check("rst_ready", {31'd0, upd_ready}, 32'd1);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    rst_n = 1'b1;
    wait_tick("tick0", n);
    check("tick0_dist", n, 32'd128);
    wait_tick("tick1", n);
    check("tick1_dist", n, 32'd128);
    step(1);
    check("tick_width", {31'd0, frame_tick}, 32'd0);

    // 2. mid-frame offer, commit at boundary
    step(39);
    upd_digits = 16'h1234; upd_dp = 4'b0001; upd_blank = 4'b0000; bright = 4'hF;
    upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
    check("cap_ready", {31'd0, upd_ready}, 32'd0);
    check("pre_commit_dark", {28'd0, an}, 32'hF);
    wait_tick("tick_a", n);
    check("a_ready", {31'd0, upd_ready}, 32'd1);
    step(1);
    check_digit("a_d0", 4'b1110, 7'h19, 1'b0);
    step(32);
    check_digit("a_d1", 4'b1101, 7'h30, 1'b1);
    step(32);
    check_digit("a_d2", 4'b1011, 7'h24, 1'b1);
    step(32);
    check_digit("a_d3", 4'b0111, 7'h79, 1'b1);

    // 3. hold valid while pending
    wait_tick("tick_f2", n);
    step(10);
    upd_digits = 16'h5678; upd_dp = 4'b0000; upd_valid = 1'b1;
    step(1);
    upd_digits = 16'h9ABC;
    check("hold_ready", {31'd0, upd_ready}, 32'd0);
    rdy_cnt = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!frame_tick && upd_ready) rdy_cnt++;
    end while (!frame_tick && n < 300);
    check("hold_tick", {31'd0, frame_tick}, 32'd1);
    check("hold_ready_cnt", rdy_cnt, 32'd0);
    check("x_commit_ready", {31'd0, upd_ready}, 32'd1);
    step(1);
    upd_valid = 1'b0;
    check("y_cap_ready", {31'd0, upd_ready}, 32'd0);
    check_digit("x_d0", 4'b1110, 7'h00, 1'b1);
    step(32);
    check_digit("x_d1", 4'b1101, 7'h78, 1'b1);
    step(64);
    check_digit("x_d3", 4'b0111, 7'h12, 1'b1);
    wait_tick("tick_y", n);
    step(1);
    check_digit("y_d0", 4'b1110, 7'h46, 1'b1);
    step(32);
    check_digit("y_d1", 4'b1101, 7'h03, 1'b1);

    // 4. brightness duty per digit
    bright = 4'h0;
    wait_tick("tick_b0", n);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int i = 0; i < 128; i++) begin
      step(1);
      for (int k = 0; k < 4; k++) if (an[k] == 1'b0) cnt[k]++;
    end
    for (int k = 0; k < 4; k++) check($sformatf("b0_duty%0d", k), cnt[k], 32'd2);
    check("b0_tick", {31'd0, frame_tick}, 32'd1);
    bright = 4'h7;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int i = 0; i < 128; i++) begin
      step(1);
      for (int k = 0; k < 4; k++) if (an[k] == 1'b0) cnt[k]++;
    end
    for (int k = 0; k < 4; k++) check($sformatf("b7_duty%0d", k), cnt[k], 32'd16);
    check("b7_tick", {31'd0, frame_tick}, 32'd1);

    // 5. blank mask
    bright = 4'hF;
    upd_digits = 16'hFEDC; upd_dp = 4'b0000; upd_blank = 4'b0100; upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
    wait_tick("tick_bl", n);
    step(1);
    check_digit("bl_d0", 4'b1110, 7'h46, 1'b1);
    step(32);
    check_digit("bl_d1", 4'b1101, 7'h21, 1'b1);
    step(32);
    check_digit("bl_d2a", 4'hF, 7'h7F, 1'b1);
    step(15);
    check_digit("bl_d2b", 4'hF, 7'h7F, 1'b1);
    step(17);
    check_digit("bl_d3", 4'b0111, 7'h0E, 1'b1);

    // 6. reset mid-slot with pending data
    upd_digits = 16'h0000; upd_dp = 4'hF; upd_blank = 4'h0; upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
    check("r_pend_ready", {31'd0, upd_ready}, 32'd0);
    step(5);
    rst_n = 1'b0;
    #1;
    check_digit("r_async", 4'hF, 7'h7F, 1'b1);
    check("r_ready", {31'd0, upd_ready}, 32'd1);
    check("r_tick", {31'd0, frame_tick}, 32'd0);
    step(3);
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      dark_cnt = 0; tick_cnt = 0;
      for (int i = 0; i < 128; i++) begin
        step(1);
        if (an != 4'hF || seg != 7'h7F || dp != 1'b1) dark_cnt++;
        if (frame_tick && i != 127) tick_cnt++;
      end
      check($sformatf("r_dark%0d", f), dark_cnt, 32'd0);
      check($sformatf("r_early_tick%0d", f), tick_cnt, 32'd0);
      check($sformatf("r_tick_at128_%0d", f), {31'd0, frame_tick}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan.md
Name: sev_seg_scan

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display. It accepts a packed hex value plus per-digit decimal-point and blank masks through a valid/ready handshake. It scans one digit at a time, uses a 4-bit PWM brightness control, and commits new values only at frame boundaries so the display never shows a torn frame. It sits between the datapath or debug registers and the board display pins, and replaces a per-digit combinational decoder.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
SUB_DIV, 6250, clk cycles per PWM subslot; one digit slot = 16*SUB_DIV cycles
ACTIVE_LOW, 1, 1 = an/seg/dp driven active-low; 0 = all three outputs inverted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
upd_valid  in  1  new display contents offered
upd_ready  out  1  block can accept contents (no commit pending)
upd_digits  in  4*NUM_DIGITS  hex nibble per digit; nibble i -> digit i
upd_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
upd_blank  in  NUM_DIGITS  per-digit blank, 1 = digit dark
bright  in  4  brightness level, sampled live; 0 = 1/16 duty, 15 = full
an  out  NUM_DIGITS  digit enables, one-hot (active-low when ACTIVE_LOW=1)
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point segment
frame_tick  out  1  one-cycle pulse on each frame boundary

Behaviour:
- Counters: sub_cnt 0..SUB_DIV-1; phase 0..15 advances when sub_cnt wraps; digit_idx 0..NUM_DIGITS-1 advances when phase wraps from 15. digit_idx wraps to 0 at the frame boundary.
- Frame boundary: the cycle in which digit_idx goes from NUM_DIGITS-1 to 0. frame_tick is 1 in the cycle after that transition (registered).
- Handshake: upd_ready = !pend. On upd_valid && upd_ready, capture digits/dp/blank into the pending register and set pend. upd_valid without ready is ignored; the source holds the data.
- Commit: at the frame boundary, if pend=1, copy pending to the active register and clear pend. upd_ready is high from the next cycle.
- Simultaneous capture and boundary: a capture requires pend=0, so nothing commits that cycle. The captured data commits at the following boundary, one frame later.
- Digit lit condition: phase <= bright AND active_blank[digit_idx]=0.
- When lit: the an bit for digit_idx is asserted, seg = decode(active nibble), dp = active_dp bit.
- When not lit: all an bits are deasserted, seg is all off, dp is off.
- Decode uses active-low internal patterns:
  0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Output polarity: when ACTIVE_LOW=0, an, seg and dp are bitwise inverted.
- Latency: outputs are registered one cycle after the counter state that selects them.
- Reset (async, rst_n=0):
  - counters are 0 and pend=0, so upd_ready=1
  - active blank mask is all ones; active digits and dp are 0
  - an, seg and dp are all inactive (all ones when ACTIVE_LOW=1); frame_tick=0
- Reset mid-frame discards pending and active contents. Scanning restarts at digit 0, phase 0 after rst_n deasserts.
- bright changes take effect at the next phase comparison, with no glitch beyond one subslot.

Decomposition:
- Package sev_seg_pkg: the 16 segment pattern constants (active-low), SEG_OFF, and the PHASES=16 constant.
- One sub-module, hex7_decode: purely combinational, 4-bit nibble in, 7-bit active-low pattern out, no default hole.
- The scan counters, handshake and output registers stay in sev_seg_scan.

Test Plan:
All scenarios use NUM_DIGITS=4, SUB_DIV=2, ACTIVE_LOW=1, so a slot is 32 cycles and a frame is 128 cycles.
1. Reset then idle: an=4'hF, seg=7'h7F, dp=1, upd_ready=1. frame_tick pulses every 128 cycles.
2. Offer digits=16'h1234, dp=4'b0001, blank=0, bright=15 mid-frame: ready drops the next cycle. Display stays dark until the boundary. Next frame shows digit0 an=1110 seg=7'h19 dp=0, then digit1 seg=7'h30, digit2 seg=7'h24, digit3 seg=7'h79. ready=1 after the commit.
3. Hold upd_valid with new data while pend=1: no capture, and ready stays 0 until the boundary. The second value displays one frame after its own capture.
4. bright=0: each digit's an is asserted for 2 of 32 slot cycles (phase 0 only). bright=7: asserted for 16 of 32 cycles.
5. blank=4'b0100 with digits=16'hFEDC: digit2 slot has an=4'hF and seg=7'h7F. Other digits show 7'h46, 7'h21, 7'h0E.
6. Assert rst_n=0 mid-slot while pend=1: outputs go inactive immediately and ready=1. After release, the display is dark and scanning starts at digit 0.
